handshake_rr_arbiter: RTL
=========================

// Module: handshake_rr_arbiter
// PURPOSE
// Shares one downstream valid/ready handshake stream between NUM_REQ upstream
// handshake masters. Uses round-robin arbitration with an optional packet lock.
// Sits between several handshake_master-style sources and one handshake_slave-
// style sink. The output stage is registered and sustains 1 beat/cycle.
// PARAMETERS
// NUM_REQ    4  number of requester ports (>=2)
// DATA_BITS  8  payload width per beat
// PKT_MODE   0  0: re-arbitrate every beat; 1: hold grant until s_last beat accepted
// PORTS
// clk      in   1                    clock; all logic on rising edge
// rst      in   1                    synchronous reset, active-high
// s_valid  in   NUM_REQ              per-requester valid
// s_ready  out  NUM_REQ              per-requester ready (one-hot or zero)
// s_data   in   NUM_REQ*DATA_BITS    requester i payload at [i*DATA_BITS +: DATA_BITS]
// s_last   in   NUM_REQ              per-requester end-of-packet (ignored if PKT_MODE=0)
// m_valid  out  1                    output valid (registered)
// m_ready  in   1                    output ready from sink
// m_data   out  DATA_BITS            output payload (registered)
// m_sel    out  $clog2(NUM_REQ)      index of requester that sourced m_data
// m_last   out  1                    registered copy of accepted s_last (0 if PKT_MODE=0)
// BEHAVIOUR
// - Reset (rst=1 at posedge): m_valid=0, m_data=0, m_sel=0, m_last=0, ptr=0, lock=0.
//   s_ready=0 while rst=1. Reset mid-packet drops lock and the output beat silently.
// - Output register "free" = !m_valid || m_ready (drain and refill in the same cycle).
// - Grant g: first i with s_valid[i]=1, scanning ptr, ptr+1, ... wrapping mod NUM_REQ.
//   When lock=1, g = locked index regardless of other requests.
// - s_ready[g] = free && s_valid[g] (or lock held); all other s_ready bits are 0.
//   s_ready never depends on a non-granted s_valid.
// - Accept = s_valid[g] && s_ready[g]. Next cycle: m_valid=1, m_data=s_data[g],
//   m_sel=g, m_last=s_last[g]&PKT_MODE. Latency is exactly 1 clk from accept to m_valid.
// - Free && no accept: m_valid<=0. m_valid=1 && m_ready=0: m_data/m_sel/m_last held stable.
// - PKT_MODE=0: on accept, ptr <= (g+1) mod NUM_REQ.
// - PKT_MODE=1 states:
//   IDLE->LOCKED on accept with s_last[g]=0 (lock idx=g, ptr unchanged).
//   Accept with s_last[g]=1 from either state -> IDLE, ptr <= (g+1) mod NUM_REQ.
//   LOCKED while locked requester deasserts s_valid: stay LOCKED, no other port granted.
// - No requests: no accepts, ptr unchanged. A single active requester gets 1 beat/cycle
//   while m_ready=1.
// - No beat is duplicated or dropped. Output order per requester equals input order.
// TESTING
// 1 Reset: hold rst 3 clks with all s_valid=1 -> s_ready=0, m_valid=0, m_sel=0 throughout.
// 2 Single src: port2 sends A5,C4 with m_ready=1 -> m_data A5 then C4 on consecutive
//   clks, m_sel=2, each 1 clk after its s_ready handshake.
// 3 Round-robin: ports 0..3 all valid continuously, m_ready=1 -> m_sel=0,1,2,3,0,...
//   Each port sees 1 accept per 4 clks.
// 4 Backpressure: sink drives m_ready=0 for 5 clks while holding beat 3C -> m_valid=1,
//   m_data=3C stable, all s_ready=0. Resumes without loss.
// 5 Packet lock (PKT_MODE=1): port1 sends 11,22,33(last) with a 2-clk valid gap, port0
//   valid throughout -> m_sel=1,1,1 then 0. Port0 not granted during the gap.
// 6 Random: random s_valid/m_ready for 10k clks -> scoreboard per-port order preserved,
//   no loss, and no port starved for more than NUM_REQ grants.

Source files
------------

// File: rtl/handshake_rr_arbiter_if.sv
// Signal bundle for the round-robin arbiter: NUM_REQ upstream valid/ready/data/last
// streams plus the single registered downstream stream.
interface handshake_rr_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    localparam int SEL_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]           s_valid;
    logic [NUM_REQ-1:0]           s_ready;
    logic [NUM_REQ*DATA_BITS-1:0] s_data;
    logic [NUM_REQ-1:0]           s_last;
    logic                         m_valid;
    logic                         m_ready;
    logic [DATA_BITS-1:0]         m_data;
    logic [SEL_BITS-1:0]          m_sel;
    logic                         m_last;

    // master: whoever feeds the requesters and sinks the output stream
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_sel, m_last
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_sel, m_last
    );
endinterface

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter merging NUM_REQ valid/ready streams into one registered
// output stream, with optional grant lock held until the end-of-packet beat.
module handshake_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int PKT_MODE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    handshake_rr_arbiter_if.slave bus
);
    localparam int SEL_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t               state_reg, state_next;
    logic [SEL_BITS-1:0]  ptr_reg, ptr_next;
    logic [SEL_BITS-1:0]  lock_idx_reg, lock_idx_next;
    logic [SEL_BITS-1:0]  scan_offset, scan_grant, grant, grant_inc;
    logic [NUM_REQ-1:0]   rot_valid;
    logic [NUM_REQ-1:0]   ready_vec;
    logic [DATA_BITS-1:0] data_arr [NUM_REQ];
    logic                 free, grant_valid, grant_last, accept;

    logic                 m_valid_reg;
    logic [DATA_BITS-1:0] m_data_reg;
    logic [SEL_BITS-1:0]  m_sel_reg;
    logic                 m_last_reg;

    // (a + b) mod NUM_REQ for a < NUM_REQ, 0 <= b < NUM_REQ; works for any NUM_REQ
    function automatic logic [SEL_BITS-1:0] wrap_add(input logic [SEL_BITS-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return SEL_BITS'(s);
    endfunction

    // rot_valid[k] is the request k places after the pointer
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
        assign data_arr[gi]  = bus.s_data[gi*DATA_BITS +: DATA_BITS];
        assign rot_valid[gi] = bus.s_valid[wrap_add(ptr_reg, gi)];
    end

    always_comb begin
        scan_offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) scan_offset = SEL_BITS'(k);
        end
        scan_grant = wrap_add(ptr_reg, int'(scan_offset));
    end

    assign grant       = (state_reg == ST_LOCKED) ? lock_idx_reg : scan_grant;
    assign grant_inc   = wrap_add(grant, 1);
    assign grant_valid = bus.s_valid[grant];
    assign grant_last  = bus.s_last[grant];
    assign free        = !m_valid_reg || bus.m_ready;
    assign accept      = free && grant_valid && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            lock_idx_reg <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            lock_idx_reg <= lock_idx_next;
        end
    end

    // A non-last beat in packet mode pins the grant; the pointer only advances
    // once the packet (or single beat) is finished.
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        lock_idx_next = lock_idx_reg;
        if (accept) begin
            if ((PKT_MODE != 0) && !grant_last) begin
                state_next    = ST_LOCKED;
                lock_idx_next = grant;
            end else begin
                state_next    = ST_IDLE;
                ptr_next      = grant_inc;
            end
        end
    end

    always_comb begin
        ready_vec = '0;
        if (accept) ready_vec[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_sel_reg   <= '0;
            m_last_reg  <= 1'b0;
        end else if (free) begin
            m_valid_reg <= accept;
            if (accept) begin
                m_data_reg <= data_arr[grant];
                m_sel_reg  <= grant;
                m_last_reg <= grant_last && (PKT_MODE != 0);
            end
        end
    end

    assign bus.s_ready = ready_vec;
    assign bus.m_valid = m_valid_reg;
    assign bus.m_data  = m_data_reg;
    assign bus.m_sel   = m_sel_reg;
    assign bus.m_last  = m_last_reg;
endmodule
